// File: rtl/split_arbiter.sv
// Two-requester round-robin arbiter that serialises a granted 32-bit word
// into four bytes on a ready/valid output, in the byte order set by MSB_FIRST.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no word in flight; a pending request is granted and acked here
// SEND  | word register holds the granted word; byte cnt is presented
module split_arbiter #(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        ack1,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        out_src,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        src_q, src_d;
    logic        last_grant_q, last_grant_d;

    logic        grant_vld;
    logic        grant_idx;
    logic        xfer;
    logic [1:0]  byte_sel;
    logic [7:0]  byte_mux;

    // Reset wins over a same-cycle grant, so no ack is shown for a capture
    // that will never happen.
    always_comb begin
        grant_vld = (state_q == ST_IDLE) && (req0 || req1) && !reset;
        if (req0 && req1) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = req1;
        end
    end

    assign ack0 = grant_vld && !grant_idx;
    assign ack1 = grant_vld && grant_idx;
    assign xfer = (state_q == ST_SEND) && out_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    word_d       = grant_idx ? data1 : data0;
                    src_d        = grant_idx;
                    last_grant_d = grant_idx;
                    cnt_d        = 2'd0;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 2'd0;
            word_q       <= 32'h0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Map the transfer index onto a physical byte lane.
    assign byte_sel = (MSB_FIRST != 0) ? (2'd3 - cnt_q) : cnt_q;

    always_comb begin
        case (byte_sel)
            2'd0:    byte_mux = word_q[7:0];
            2'd1:    byte_mux = word_q[15:8];
            2'd2:    byte_mux = word_q[23:16];
            default: byte_mux = word_q[31:24];
        endcase
    end

    assign busy      = (state_q == ST_SEND);
    assign out_valid = busy;
    assign out_byte  = busy ? byte_mux : 8'h00;
    assign out_last  = busy && (cnt_q == 2'd3);
    assign out_src   = src_q;

endmodule

// File: tb/tb_split_arbiter.sv
// Bench for split_arbiter: drives both byte orders side by side and checks them
// every cycle against a queue-based model, plus literal expectations.
module tb_split_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] data0, data1;
    logic        out_ready;

    logic        ack0_m, ack1_m, valid_m, last_m, src_m, busy_m;
    logic [7:0]  byte_m;
    logic        ack0_l, ack1_l, valid_l, last_l, src_l, busy_l;
    logic [7:0]  byte_l;

    int checks = 0;
    int errors = 0;

    // model: pending bytes of the word in flight, per byte order
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];
    logic       last_g = 1'b1;
    logic       owner  = 1'b0;
    logic       grants[$];

    split_arbiter #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0_m),
        .req1(req1), .data1(data1), .ack1(ack1_m),
        .out_valid(valid_m), .out_byte(byte_m), .out_last(last_m),
        .out_src(src_m), .out_ready(out_ready), .busy(busy_m)
    );

    split_arbiter #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0_l),
        .req1(req1), .data1(data1), .ack1(ack1_l),
        .out_valid(valid_l), .out_byte(byte_l), .out_last(last_l),
        .out_src(src_l), .out_ready(out_ready), .busy(busy_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs against the model, then advance the model over the
    // coming rising edge using the (stable) current inputs.
    task automatic model_cmp();
        logic       e_valid;
        logic [7:0] e_bm, e_bl;
        logic       e_last, g_vld, g_idx;
        logic [31:0] w;
        e_valid = (q_m.size() != 0);
        e_bm    = e_valid ? q_m[0] : 8'h00;
        e_bl    = e_valid ? q_l[0] : 8'h00;
        e_last  = (q_m.size() == 1);
        g_vld   = !reset && !e_valid && (req0 || req1);
        g_idx   = (req0 && req1) ? !last_g : req1;

        chk("m.ack0", ack0_m, g_vld && !g_idx);
        chk("m.ack1", ack1_m, g_vld && g_idx);
        chk("m.valid", valid_m, e_valid);
        chk("m.busy", busy_m, e_valid);
        chk("m.byte", byte_m, e_bm);
        chk("m.last", last_m, e_last);
        chk("m.src", src_m, owner);
        chk("l.ack0", ack0_l, g_vld && !g_idx);
        chk("l.ack1", ack1_l, g_vld && g_idx);
        chk("l.valid", valid_l, e_valid);
        chk("l.byte", byte_l, e_bl);
        chk("l.last", last_l, e_last);
        chk("l.src", src_l, owner);

        if (reset) begin
            q_m.delete();
            q_l.delete();
            last_g = 1'b1;
            owner  = 1'b0;
        end else if (e_valid && out_ready) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end else if (g_vld) begin
            w = g_idx ? data1 : data0;
            for (int i = 0; i < 4; i++) begin
                q_m.push_back(w[31-8*i -: 8]);
                q_l.push_back(w[8*i +: 8]);
            end
            owner  = g_idx;
            last_g = g_idx;
        end
    endtask

    task automatic neg();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    // One word from src; the source data is corrupted right after the ack.
    task automatic send(input logic src, input logic [31:0] w,
                        input logic [31:0] em, input logic [31:0] el);
        if (src) begin req1 = 1'b1; data1 = w; end
        else     begin req0 = 1'b1; data0 = w; end
        neg();
        chk("lit.ack0", ack0_m, !src);
        chk("lit.ack1", ack1_m, src);
        pos();
        req0 = 1'b0;
        req1 = 1'b0;
        if (src) data1 = ~w; else data0 = ~w;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("lit.byte_m", byte_m, em[31-8*i -: 8]);
            chk("lit.byte_l", byte_l, el[31-8*i -: 8]);
            chk("lit.last", last_m, (i == 3));
            chk("lit.src", src_m, src);
            pos();
        end
        neg();
        chk("lit.idle_valid", valid_m, 1'b0);
        pos();
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = 32'h0; data1 = 32'h0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        neg();
        pos();
        reset = 1'b0;
        neg();
        chk("rst.valid", valid_m, 1'b0);
        chk("rst.byte", byte_m, 8'h00);
        chk("rst.last", last_m, 1'b0);
        chk("rst.busy", busy_m, 1'b0);
        chk("rst.src", src_m, 1'b0);
        pos();

        send(1'b0, 32'h11223344, 32'h11223344, 32'h44332211);
        send(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE);

        // Both requesters held high right after reset: 0,1,0,1
        reset = 1'b1;
        neg();
        pos();
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        data0 = 32'hA0A1A2A3; data1 = 32'hB0B1B2B3;
        grants.delete();
        for (int c = 0; c < 22; c++) begin
            neg();
            chk("rr.no_overlap", ack0_m && ack1_m, 1'b0);
            if (ack0_m || ack1_m) grants.push_back(ack1_m);
            pos();
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("rr.count", grants.size(), 32'd5);
        if (grants.size() >= 4) begin
            chk("rr.g0", grants[0], 1'b0);
            chk("rr.g1", grants[1], 1'b1);
            chk("rr.g2", grants[2], 1'b0);
            chk("rr.g3", grants[3], 1'b1);
        end
        for (int c = 0; c < 5; c++) begin
            neg();
            pos();
        end

        // Stall for three cycles while byte 2 is presented
        req0 = 1'b1; data0 = 32'h11223344;
        neg();
        pos();
        req0 = 1'b0;
        neg(); chk("st.b0", byte_m, 8'h11); pos();
        neg(); chk("st.b1", byte_m, 8'h22); pos();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            neg();
            chk("st.hold", byte_m, 8'h33);
            chk("st.hold_l", byte_l, 8'h22);
            chk("st.hold_last", last_m, 1'b0);
            pos();
        end
        out_ready = 1'b1;
        neg(); chk("st.b2", byte_m, 8'h33); pos();
        neg(); chk("st.b3", byte_m, 8'h44); chk("st.last", last_m, 1'b1); pos();
        neg(); chk("st.done", valid_m, 1'b0); pos();

        // Reset in the middle of a word, then a fresh request from 1
        req0 = 1'b1; data0 = 32'h11223344;
        neg();
        pos();
        req0 = 1'b0;
        neg(); pos();
        neg(); pos();
        reset = 1'b1;
        neg(); chk("mr.pre", byte_m, 8'h33); pos();
        reset = 1'b0;
        neg();
        chk("mr.valid", valid_m, 1'b0);
        chk("mr.busy", busy_m, 1'b0);
        pos();
        send(1'b1, 32'h55667788, 32'h55667788, 32'h88776655);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
